// File: rtl/ff_readback_pkg.sv
// ff_readback_pkg: shared FSM state type and width limits for the FF readback engine.
package ff_readback_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rb_state_t;
  localparam int RB_WIDTH_MAX     = 1024;
  localparam int RB_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/rb_shift_reg.sv
// rb_shift_reg: loadable right-shift shadow register; bit 0 is the next bit to stream.
module rb_shift_reg
  import ff_readback_pkg::*;
#(
  parameter int WIDTH = RB_WIDTH_DEFAULT
) (
  input  logic             QCK,
  input  logic             QRN,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge QCK or negedge QRN)
    if (!QRN) r_q <= '0;
    else r_q <= load ? d : shift ? r_q >> 1 : r_q;
  assign q0 = r_q[0];
endmodule

// File: rtl/ff_readback.sv
// ff_readback: snapshots a row of FF outputs on CAP and streams it LSB-first
// over a valid/ready serial port, flagging captures dropped mid-stream.
module ff_readback #(
  parameter int WIDTH = ff_readback_pkg::RB_WIDTH_DEFAULT
) (
  (* CLOCK *) (* clkbuf_sink *)
  input  logic             QCK,
  input  logic             QRN,
  input  logic [WIDTH-1:0] QIN,
  input  logic             CAP,
  output logic             SDO,
  output logic             SVLD,
  input  logic             SRDY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR
);
  import ff_readback_pkg::rb_state_t;
  localparam int CNT_W = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  rb_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_svld, r_busy, r_done, r_ovr;
  logic w_in_shift, w_load, w_shift, w_ovr_set;
  // A capture is honoured from IDLE or DONE; in SHIFT it is dropped and remembered in OVR.
  always_comb begin
    w_in_shift = r_state == ff_readback_pkg::SHIFT;
    w_load     = !w_in_shift && CAP;
    w_shift    = w_in_shift && SRDY;
    w_ovr_set  = w_in_shift && CAP;
    w_next     = w_load ? ff_readback_pkg::SHIFT :
                 w_in_shift ? ((w_shift && r_cnt == LAST) ? ff_readback_pkg::DONE : ff_readback_pkg::SHIFT) :
                 ff_readback_pkg::IDLE;
  end
  // Flags are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge QCK or negedge QRN)
    if (!QRN) begin
      r_state <= ff_readback_pkg::IDLE;
      r_cnt   <= '0;
      r_svld  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_load ? '0 : w_shift ? r_cnt + 1'b1 : r_cnt;
      r_svld  <= w_next == ff_readback_pkg::SHIFT;
      r_busy  <= w_next != ff_readback_pkg::IDLE;
      r_done  <= w_next == ff_readback_pkg::DONE;
      r_ovr   <= w_load ? 1'b0 : r_ovr | w_ovr_set;
    end
  rb_shift_reg #(.WIDTH(WIDTH)) u_shadow (
    .QCK  (QCK),
    .QRN  (QRN),
    .load (w_load),
    .shift(w_shift),
    .d    (QIN),
    .q0   (SDO)
  );
  assign SVLD = r_svld;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign OVR  = r_ovr;
endmodule

// File: tb/tb_ff_readback.sv
// tb_ff_readback: directed checks of ff_readback at widths 32, 8, 4 and 1.
module tb_ff_readback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] q32; logic c32, r32, s32, v32, b32, d32, o32;
  logic [7:0]  q8;  logic c8, r8, s8, v8, b8, d8, o8;
  logic [3:0]  q4;  logic c4, r4, s4, v4, b4, d4, o4;
  logic [0:0]  q1;  logic c1, r1, s1, v1, b1, d1, o1;

  ff_readback #(.WIDTH(32)) u32 (.QCK(clk), .QRN(rst_n), .QIN(q32), .CAP(c32), .SDO(s32), .SVLD(v32), .SRDY(r32), .BUSY(b32), .DONE(d32), .OVR(o32));
  ff_readback #(.WIDTH(8))  u8  (.QCK(clk), .QRN(rst_n), .QIN(q8),  .CAP(c8),  .SDO(s8),  .SVLD(v8),  .SRDY(r8),  .BUSY(b8),  .DONE(d8),  .OVR(o8));
  ff_readback #(.WIDTH(4))  u4  (.QCK(clk), .QRN(rst_n), .QIN(q4),  .CAP(c4),  .SDO(s4),  .SVLD(v4),  .SRDY(r4),  .BUSY(b4),  .DONE(d4),  .OVR(o4));
  ff_readback #(.WIDTH(1))  u1  (.QCK(clk), .QRN(rst_n), .QIN(q1),  .CAP(c1),  .SDO(s1),  .SVLD(v1),  .SRDY(r1),  .BUSY(b1),  .DONE(d1),  .OVR(o1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pat32;
    logic [7:0] pat8;
    logic [3:0] vals4 [3];
    logic [3:0] pat4;
    logic [3:0] stall;
    int hs, cyc;
    {q32, c32, r32} = '0;
    {q8, c8, r8} = '0;
    {q4, c4, r4} = '0;
    {q1, c1, r1} = '0;
    tick(); tick();
    // {SVLD,SDO,BUSY,DONE,OVR} all clear in reset
    chk("reset_u8", {27'd0, v8, s8, b8, d8, o8}, 32'd0);
    chk("reset_u32", {27'd0, v32, s32, b32, d32, o32}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {27'd0, v8, s8, b8, d8, o8}, 32'd0);

    // reset mid-stream, WIDTH=32
    pat32 = 32'hA5A5_0F0F;
    q32 = pat32; c32 = 1'b1; r32 = 1'b1;
    tick();
    c32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("w32_bit%0d", i), {30'd0, v32, s32}, {30'd0, 1'b1, pat32[i]});
      tick();
    end
    chk("w32_bit5_before_rst", {30'd0, v32, s32}, {30'd0, 1'b1, pat32[5]});
    rst_n = 1'b0;
    #1;
    chk("w32_async_reset", {27'd0, v32, s32, b32, d32, o32}, 32'd0);
    tick();
    chk("w32_no_done_in_reset", {31'd0, d32}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("w32_idle_after_release", {29'd0, v32, b32, d32}, 32'd0);

    // basic stream, WIDTH=8; QIN changes after capture must not matter
    pat8 = 8'b1011_0010;
    q8 = pat8; c8 = 1'b1; r8 = 1'b1;
    tick();
    c8 = 1'b0; q8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("basic_bit%0d", i), {28'd0, v8, s8, b8, d8}, {28'd0, 1'b1, pat8[i], 1'b1, 1'b0});
      tick();
    end
    chk("basic_done", {29'd0, v8, b8, d8}, {29'd0, 3'b011});
    tick();
    chk("basic_idle", {29'd0, v8, b8, d8}, 32'd0);

    // backpressure: SRDY pattern 1,0,0,1 repeating
    pat8 = 8'hC6;
    stall = 4'b1001;
    q8 = pat8; c8 = 1'b1; r8 = 1'b0;
    tick();
    c8 = 1'b0;
    hs = 0; cyc = 0;
    while (v8 && cyc < 60) begin
      if (hs < 8) chk($sformatf("bp_bit%0d_cyc%0d", hs, cyc), {31'd0, s8}, {31'd0, pat8[hs]});
      r8 = stall[cyc % 4];
      tick();
      if (r8) hs++;
      cyc++;
    end
    chk("bp_handshakes", hs, 8);
    chk("bp_done", {30'd0, d8, b8}, 32'd3);
    r8 = 1'b0;
    tick();
    chk("bp_idle", {31'd0, b8}, 32'd0);

    // overrun: CAP again while bit 3 is presented
    pat8 = 8'h5A;
    q8 = pat8; c8 = 1'b1; r8 = 1'b1;
    tick();
    c8 = 1'b0;
    chk("ovr_clear_at_start", {31'd0, o8}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_bit%0d", i), {30'd0, v8, s8}, {30'd0, 1'b1, pat8[i]});
      if (i == 3) begin c8 = 1'b1; q8 = 8'h00; end
      tick();
      c8 = 1'b0;
      if (i == 3) chk("ovr_set", {31'd0, o8}, 32'd1);
    end
    chk("ovr_done", {30'd0, d8, o8}, 32'd3);
    tick();
    chk("ovr_sticky_idle", {30'd0, b8, o8}, 32'd1);
    q8 = 8'h01; c8 = 1'b1;
    tick();
    c8 = 1'b0;
    chk("ovr_cleared_by_cap", {29'd0, v8, s8, o8}, {29'd0, 3'b110});
    for (int i = 0; i < 9; i++) tick();
    chk("ovr_second_idle", {30'd0, b8, o8}, 32'd0);

    // back-to-back, WIDTH=4, CAP held, QIN changing every cycle
    vals4[0] = 4'b1101; vals4[1] = 4'b0110; vals4[2] = 4'b1001;
    r4 = 1'b1; c4 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      q4 = vals4[s];
      tick();
      pat4 = vals4[s];
      chk($sformatf("b2b%0d_ovr_clear", s), {30'd0, b4, o4}, 32'd2);
      for (int i = 0; i < 4; i++) begin
        q4 = ~pat4 ^ 4'(i);
        chk($sformatf("b2b%0d_bit%0d", s, i), {30'd0, v4, s4}, {30'd0, 1'b1, pat4[i]});
        tick();
      end
      chk($sformatf("b2b%0d_done_ovr", s), {29'd0, v4, d4, o4}, 32'd3);
    end
    c4 = 1'b0;
    tick();
    chk("b2b_idle", {31'd0, b4}, 32'd0);

    // degenerate WIDTH=1
    q1 = 1'b1; c1 = 1'b1; r1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("w1_shift", {29'd0, v1, s1, d1}, 32'd6);
    tick();
    chk("w1_done", {29'd0, v1, b1, d1}, 32'd3);
    tick();
    chk("w1_idle", {29'd0, v1, b1, d1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
